// File: rtl/regfile_pkg.sv
// Shared register-file types and constants.
// Used by the write-back queue and the register file itself.
package regfile_pkg;

  localparam int REG_AW    = 4;
  localparam int REG_DW    = 32;
  localparam int REG_COUNT = 16;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_match.sv
// Youngest-first priority matcher over the pending write-back entries.
// Returns the data of the most recent occupied entry targeting lkAddr.
module regfile_wb_match
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  wb_entry_t         entries [DEPTH],
  input  logic [CW-1:0]     count,
  input  logic [PW-1:0]     tail,
  input  logic [AW-1:0]     lkAddr,
  output logic              hit,
  output logic [DW-1:0]     data
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so the youngest match is the last one assigned.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx = tail - PW'(k) - PW'(1);
      if ((CW'(k) < count) &&
          (entries[idx].addr == REG_AW'(lkAddr))) begin
        hit  = 1'b1;
        data = DW'(entries[idx].data);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// In-order write-back queue driving the register-file write port.
// Optional forwarding lookup built when REGFILE_WB_FWD_EN is defined.
module regfile_wb_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wbValid,
  output logic          wbReady,
  input  logic [AW-1:0] wbAddr,
  input  logic [DW-1:0] wbData,
  input  logic          wrStall,
  output logic          write,
  output logic [AW-1:0] wrAddr,
  output logic [DW-1:0] wrData,
  input  logic [AW-1:0] lkAddr,
  output logic          lkHit,
  output logic [DW-1:0] lkData,
  output logic [CW-1:0] count
);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] occ;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full    = (occ == CW'(DEPTH));
  assign empty   = (occ == '0);
  assign wbReady = !full && !reset;
  assign write   = !empty && !wrStall && !reset;
  assign push    = wbValid && wbReady;
  assign pop     = write;
  assign count   = occ;

  assign wrAddr = empty ? '0 : AW'(mem[head].addr);
  assign wrData = empty ? '0 : DW'(mem[head].data);

  // Pointer and occupancy bookkeeping; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      unique case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Entry storage is left uninitialised; occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= '{addr: REG_AW'(wbAddr),
                     data: REG_DW'(wbData)};
    end
  end

`ifdef REGFILE_WB_FWD_EN
  logic          matchHit;
  logic [DW-1:0] matchData;

  regfile_wb_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) uMatch (
    .entries (mem),
    .count   (occ),
    .tail    (tail),
    .lkAddr  (lkAddr),
    .hit     (matchHit),
    .data    (matchData)
  );

  assign lkHit  = matchHit && !reset;
  assign lkData = reset ? '0 : matchData;
`else
  logic lkUnused;

  assign lkUnused = ^lkAddr;
  assign lkHit    = 1'b0;
  assign lkData   = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed testbench for regfile_wb_queue.
// Expected forwarding results follow REGFILE_WB_FWD_EN.
module tb_regfile_wb_queue;

`ifdef REGFILE_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        wbValid;
  logic        wbReady;
  logic [3:0]  wbAddr;
  logic [31:0] wbData;
  logic        wrStall;
  logic        write;
  logic [3:0]  wrAddr;
  logic [31:0] wrData;
  logic [3:0]  lkAddr;
  logic        lkHit;
  logic [31:0] lkData;
  logic [2:0]  count;

  int nCmp = 0;
  int nErr = 0;

  logic [35:0] wlog [$];

  regfile_wb_queue #(.DEPTH(4), .AW(4), .DW(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .wbValid (wbValid),
    .wbReady (wbReady),
    .wbAddr  (wbAddr),
    .wbData  (wbData),
    .wrStall (wrStall),
    .write   (write),
    .wrAddr  (wrAddr),
    .wrData  (wrData),
    .lkAddr  (lkAddr),
    .lkHit   (lkHit),
    .lkData  (lkData),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (write === 1'b1) wlog.push_back({wrAddr, wrData});
  end

  task automatic drive(input logic v, input logic [3:0] a,
                       input logic [31:0] d, input logic s);
    wbValid = v;
    wbAddr  = a;
    wbData  = d;
    wrStall = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clk);
    #1;
    nCmp++; if (write !== 1'b0) begin nErr++; $display("FAIL rst_write got %b want 0", write); end
    nCmp++; if (wbReady !== 1'b0) begin nErr++; $display("FAIL rst_ready got %b want 0", wbReady); end
    nCmp++; if (lkHit !== 1'b0) begin nErr++; $display("FAIL rst_lkhit got %b want 0", lkHit); end
    reset = 1'b0;
    #1;
    nCmp++; if (wbReady !== 1'b1) begin nErr++; $display("FAIL post_rst_ready got %b want 1", wbReady); end
    nCmp++; if (write !== 1'b0) begin nErr++; $display("FAIL post_rst_write got %b want 0", write); end
    nCmp++; if (wrAddr !== 4'd0) begin nErr++; $display("FAIL post_rst_wraddr got %h want 0", wrAddr); end
    nCmp++; if (wrData !== 32'd0) begin nErr++; $display("FAIL post_rst_wrdata got %h want 0", wrData); end
    nCmp++; if (lkData !== 32'd0) begin nErr++; $display("FAIL post_rst_lkdata got %h want 0", lkData); end
    nCmp++; if (count !== 3'd0) begin nErr++; $display("FAIL post_rst_count got %0d want 0", count); end
  endtask

  task automatic test_single_write;
    wlog.delete();
    drive(1'b1, 4'd5, 32'hDEADBEEF, 1'b0);
    wbValid = 1'b0;
    #1;
    nCmp++; if (write !== 1'b1) begin nErr++; $display("FAIL single_write got %b want 1", write); end
    nCmp++; if (wrAddr !== 4'd5) begin nErr++; $display("FAIL single_addr got %h want 5", wrAddr); end
    nCmp++; if (wrData !== 32'hDEADBEEF) begin nErr++; $display("FAIL single_data got %h want deadbeef", wrData); end
    nCmp++; if (count !== 3'd1) begin nErr++; $display("FAIL single_count1 got %0d want 1", count); end
    @(posedge clk);
    #1;
    nCmp++; if (count !== 3'd0) begin nErr++; $display("FAIL single_count0 got %0d want 0", count); end
    nCmp++; if (write !== 1'b0) begin nErr++; $display("FAIL single_idle got %b want 0", write); end
    nCmp++; if (wlog.size() !== 1) begin nErr++; $display("FAIL single_nwrites got %0d want 1", wlog.size()); end
  endtask

  task automatic test_backpressure;
    logic [35:0] exp;
    wlog.delete();
    for (int i = 1; i <= 4; i++) drive(1'b1, 4'(i), 32'(i * 17), 1'b1);
    nCmp++; if (count !== 3'd4) begin nErr++; $display("FAIL bp_full_count got %0d want 4", count); end
    nCmp++; if (wbReady !== 1'b0) begin nErr++; $display("FAIL bp_ready got %b want 0", wbReady); end
    nCmp++; if (write !== 1'b0) begin nErr++; $display("FAIL bp_stalled_write got %b want 0", write); end
    drive(1'b1, 4'd9, 32'h55, 1'b1);
    nCmp++; if (count !== 3'd4) begin nErr++; $display("FAIL bp_fifth_count got %0d want 4", count); end
    wbValid = 1'b0;
    wrStall = 1'b0;
    #1;
    nCmp++; if (write !== 1'b1) begin nErr++; $display("FAIL bp_release_write got %b want 1", write); end
    nCmp++; if (wrAddr !== 4'd1) begin nErr++; $display("FAIL bp_head_addr got %h want 1", wrAddr); end
    drive(1'b0, 4'd0, 32'd0, 1'b0);
    nCmp++; if (wbReady !== 1'b1) begin nErr++; $display("FAIL bp_ready_after_pop got %b want 1", wbReady); end
    nCmp++; if (count !== 3'd3) begin nErr++; $display("FAIL bp_count3 got %0d want 3", count); end
    for (int i = 0; i < 4; i++) drive(1'b0, 4'd0, 32'd0, 1'b0);
    nCmp++; if (wlog.size() !== 4) begin nErr++; $display("FAIL bp_nwrites got %0d want 4", wlog.size()); end
    for (int i = 0; i < 4; i++) begin
      exp = {4'(i + 1), 32'((i + 1) * 17)};
      nCmp++; if (wlog[i] !== exp) begin nErr++; $display("FAIL bp_order[%0d] got %h want %h", i, wlog[i], exp); end
    end
  endtask

  task automatic test_concurrent;
    logic        tv [13] = '{1,1,1,1,1,1,1,1,0,0,1,1,0};
    logic [3:0]  ta [13] = '{1,2,3,4,5,6,7,8,0,0,9,10,0};
    logic        ts [13] = '{1,1,0,0,0,1,0,0,0,0,0,0,0};
    logic [2:0]  tc [13] = '{1,2,2,2,2,3,3,3,2,1,1,1,0};
    logic [35:0] exp;
    wlog.delete();
    for (int i = 0; i < 13; i++) begin
      drive(tv[i], ta[i], 32'(100) + 32'(ta[i]), ts[i]);
      nCmp++; if (count !== tc[i]) begin nErr++; $display("FAIL conc_count[%0d] got %0d want %0d", i, count, tc[i]); end
    end
    drive(1'b0, 4'd0, 32'd0, 1'b0);
    nCmp++; if (wlog.size() !== 10) begin nErr++; $display("FAIL conc_nwrites got %0d want 10", wlog.size()); end
    for (int i = 0; i < 10; i++) begin
      exp = {4'(i + 1), 32'(101 + i)};
      nCmp++; if (wlog[i] !== exp) begin nErr++; $display("FAIL conc_order[%0d] got %h want %h", i, wlog[i], exp); end
    end
  endtask

  task automatic test_forward;
    wlog.delete();
    drive(1'b1, 4'd7, 32'hA, 1'b1);
    drive(1'b1, 4'd7, 32'hB, 1'b1);
    drive(1'b1, 4'd3, 32'hC, 1'b1);
    wbValid = 1'b0;
    lkAddr  = 4'd7;
    #1;
    nCmp++; if (lkHit !== FWD) begin nErr++; $display("FAIL fwd_hit7 got %b want %b", lkHit, FWD); end
    nCmp++; if (lkData !== (FWD ? 32'hB : 32'h0)) begin nErr++; $display("FAIL fwd_data7 got %h", lkData); end
    lkAddr = 4'd3;
    #1;
    nCmp++; if (lkData !== (FWD ? 32'hC : 32'h0)) begin nErr++; $display("FAIL fwd_data3 got %h", lkData); end
    wbValid = 1'b1;
    wbAddr  = 4'd9;
    wbData  = 32'hD;
    lkAddr  = 4'd9;
    #1;
    nCmp++; if (lkHit !== 1'b0) begin nErr++; $display("FAIL fwd_incoming_hit got %b want 0", lkHit); end
    nCmp++; if (lkData !== 32'h0) begin nErr++; $display("FAIL fwd_incoming_data got %h want 0", lkData); end
    wbValid = 1'b0;
    lkAddr  = 4'd7;
    drive(1'b0, 4'd0, 32'd0, 1'b0);
    nCmp++; if (write !== 1'b1) begin nErr++; $display("FAIL fwd_head_write got %b want 1", write); end
    nCmp++; if (lkHit !== FWD) begin nErr++; $display("FAIL fwd_head_hit got %b want %b", lkHit, FWD); end
    nCmp++; if (lkData !== (FWD ? 32'hB : 32'h0)) begin nErr++; $display("FAIL fwd_head_data got %h", lkData); end
    drive(1'b0, 4'd0, 32'd0, 1'b0);
    nCmp++; if (lkHit !== 1'b0) begin nErr++; $display("FAIL fwd_after_pop_hit got %b want 0", lkHit); end
    nCmp++; if (lkData !== 32'h0) begin nErr++; $display("FAIL fwd_after_pop_data got %h want 0", lkData); end
    drive(1'b0, 4'd0, 32'd0, 1'b0);
    nCmp++; if (count !== 3'd0) begin nErr++; $display("FAIL fwd_drain_count got %0d want 0", count); end
    nCmp++; if (wlog.size() !== 3) begin nErr++; $display("FAIL fwd_nwrites got %0d want 3", wlog.size()); end
  endtask

  task automatic test_reset_mid;
    wlog.delete();
    for (int i = 1; i <= 3; i++) drive(1'b1, 4'(i), 32'(i + 200), 1'b1);
    nCmp++; if (count !== 3'd3) begin nErr++; $display("FAIL rmid_count3 got %0d want 3", count); end
    wbValid = 1'b0;
    wrStall = 1'b0;
    lkAddr  = 4'd2;
    reset   = 1'b1;
    #1;
    nCmp++; if (write !== 1'b0) begin nErr++; $display("FAIL rmid_write got %b want 0", write); end
    nCmp++; if (wbReady !== 1'b0) begin nErr++; $display("FAIL rmid_ready got %b want 0", wbReady); end
    nCmp++; if (lkHit !== 1'b0) begin nErr++; $display("FAIL rmid_lkhit got %b want 0", lkHit); end
    @(posedge clk);
    #1;
    nCmp++; if (write !== 1'b0) begin nErr++; $display("FAIL rmid_write2 got %b want 0", write); end
    reset = 1'b0;
    #1;
    nCmp++; if (count !== 3'd0) begin nErr++; $display("FAIL rmid_count0 got %0d want 0", count); end
    nCmp++; if (wbReady !== 1'b1) begin nErr++; $display("FAIL rmid_ready1 got %b want 1", wbReady); end
    for (int i = 0; i < 4; i++) drive(1'b0, 4'd0, 32'd0, 1'b0);
    nCmp++; if (wlog.size() !== 0) begin nErr++; $display("FAIL rmid_stale got %0d want 0", wlog.size()); end
  endtask

  initial begin
    reset   = 1'b1;
    wbValid = 1'b0;
    wbAddr  = '0;
    wbData  = '0;
    wrStall = 1'b0;
    lkAddr  = '0;
    test_reset();
    test_single_write();
    test_backpressure();
    test_concurrent();
    test_forward();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
